// File: rtl/dcsg_write_queue.sv
// dcsg_write_queue: decodes CPU OUTs to the DCSG port, buffers them in a FIFO
// and drains them into the PSG ce/wr/ready handshake at the PSG clock-enable rate.
module dcsg_write_queue #(
   parameter logic [7:0] IO_PORT    = 8'h3F,
   parameter int         DEPTH_LOG2 = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en_clk_psg_i,
   input  logic                n_ioreq,
   input  logic                n_wr,
   input  logic [15:0]         address,
   input  logic [7:0]          wdata,
   output logic                psg_ce_n,
   output logic                psg_wr_n,
   output logic [7:0]          psg_wdata,
   input  logic                psg_ready,
   output logic [DEPTH_LOG2:0] level,
   output logic                overflow,
   input  logic                clear_overflow
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;
   typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;
   state_t                state_q, state_d;
   logic                  req, req_q, push, pop, push_ok, full;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  overflow_q, overflow_d, ce_n_q, ce_n_d, wr_n_q, wr_n_d;
   logic [7:0]            wdata_q, wdata_d;
   logic [7:0]            mem [DEPTH];
   always_comb begin
      req        = !n_ioreq && !n_wr && address[7:0] == IO_PORT;
      push       = req && !req_q;
      full       = level_q == LW'(DEPTH);
      pop        = en_clk_psg_i && state_q == IDLE && level_q != '0;
      // a same-cycle pop frees the slot the full-FIFO push needs
      push_ok    = push && (!full || pop);
      wr_ptr_d   = push_ok ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
      level_d    = level_q + LW'(push_ok) - LW'(pop);
      overflow_d = (push && !push_ok) || (overflow_q && !clear_overflow);
      state_d    = state_q;
      ce_n_d     = ce_n_q;
      wr_n_d     = wr_n_q;
      wdata_d    = wdata_q;
      if (en_clk_psg_i)
         case (state_q)
            IDLE: if (pop) begin
               wdata_d = mem[rd_ptr_q];
               ce_n_d  = 1'b0;
               wr_n_d  = 1'b0;
               state_d = WAIT;
            end
            WAIT: if (psg_ready) begin
               wr_n_d  = 1'b1;
               state_d = RELEASE;
            end
            RELEASE: begin
               ce_n_d  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         ce_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         ce_n_q     <= ce_n_d;
         wr_n_q     <= wr_n_d;
         wdata_q    <= wdata_d;
      end
   end
   always_ff @(posedge clk)
      if (push_ok) mem[wr_ptr_q] <= wdata;
   assign psg_ce_n  = ce_n_q;
   assign psg_wr_n  = wr_n_q;
   assign psg_wdata = wdata_q;
   assign level     = level_q;
   assign overflow  = overflow_q;
endmodule

// File: tb/tb_dcsg_write_queue.sv
// tb_dcsg_write_queue: directed scenario tasks for dcsg_write_queue with
// hand-computed expectations and a PSG-side byte monitor.
module tb_dcsg_write_queue;
   logic        clk = 1'b0, reset = 1'b1, n_ioreq = 1'b1, n_wr = 1'b1;
   logic        psg_ready = 1'b0, clear_overflow = 1'b0;
   logic [15:0] address = '0;
   logic [7:0]  wdata = '0;
   logic        en_run = 1'b0, en_man = 1'b0, en_auto = 1'b0, en_clk_psg_i;
   logic        psg_ce_n, psg_wr_n, overflow;
   logic [7:0]  psg_wdata;
   logic [3:0]  level;
   int          en_cnt = 0, checks = 0, errors = 0;
   logic [7:0]  got [$];
   logic        prev_wr = 1'b1, prev_ce = 1'b1;
   logic [7:0]  held = '0;
   int          wr_len = 0, ce_len = 0, unstable = 0, lvl_max = 0;

   dcsg_write_queue dut (
      .clk(clk), .reset(reset), .en_clk_psg_i(en_clk_psg_i), .n_ioreq(n_ioreq),
      .n_wr(n_wr), .address(address), .wdata(wdata), .psg_ce_n(psg_ce_n),
      .psg_wr_n(psg_wr_n), .psg_wdata(psg_wdata), .psg_ready(psg_ready),
      .level(level), .overflow(overflow), .clear_overflow(clear_overflow)
   );

   always #5 clk = ~clk;
   assign en_clk_psg_i = en_run ? en_auto : en_man;

   // one enable pulse every 4 clocks, changed away from the active edge
   always @(negedge clk) begin
      en_cnt  = (en_cnt + 1) % 4;
      en_auto = en_cnt == 0;
   end

   always @(negedge clk) begin
      if (prev_wr && !psg_wr_n) begin
         got.push_back(psg_wdata);
         wr_len = 1;
      end else if (!psg_wr_n) wr_len++;
      if (prev_ce && !psg_ce_n) begin
         held   = psg_wdata;
         ce_len = 1;
      end else if (!psg_ce_n) begin
         ce_len++;
         if (psg_wdata !== held) unstable++;
      end
      if (int'(level) > lvl_max) lvl_max = int'(level);
      prev_wr = psg_wr_n;
      prev_ce = psg_ce_n;
   end

   task automatic bus_out(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      address = a; wdata = d; n_ioreq = 1'b0; n_wr = 1'b0;
      @(negedge clk);
      n_ioreq = 1'b1; n_wr = 1'b1;
   endtask

   task automatic wait_got(input int n, input string tag);
      int i = 0;
      while (got.size() < n && i < 1000) begin
         @(negedge clk);
         i++;
      end
      if (got.size() < n) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got %0d bytes want %0d", tag, got.size(), n);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (psg_ce_n !== 1'b1) begin errors++; $display("FAIL reset_ce_n: got %b want 1", psg_ce_n); end
      checks++; if (psg_wr_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n: got %b want 1", psg_wr_n); end
      checks++; if (psg_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 00", psg_wdata); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      reset  = 1'b0;
      en_run = 1'b1;
   endtask

   task automatic test_single;
      psg_ready = 1'b1;
      got.delete();
      bus_out(16'h003F, 8'h9F);
      checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level1: got %0d want 1", level); end
      wait_got(1, "single");
      repeat (20) @(negedge clk);
      checks++; if (got.size() != 1 || got[0] !== 8'h9F) begin errors++; $display("FAIL single_data: got %0d bytes first %h want 1 byte 9f", got.size(), got.size() ? got[0] : 8'h00); end
      checks++; if (wr_len != 4) begin errors++; $display("FAIL single_wr_len: got %0d want 4", wr_len); end
      checks++; if (ce_len != 8) begin errors++; $display("FAIL single_ce_len: got %0d want 8", ce_len); end
      checks++; if (psg_ce_n !== 1'b1 || psg_wr_n !== 1'b1) begin errors++; $display("FAIL single_idle_strobes: got ce=%b wr=%b want 1 1", psg_ce_n, psg_wr_n); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL single_level0: got %0d want 0", level); end
   endtask

   task automatic test_four;
      logic [7:0] exp4 [4] = '{8'h80, 8'h0F, 8'h90, 8'hA5};
      psg_ready = 1'b0;
      got.delete();
      lvl_max = 0;
      for (int k = 0; k < 4; k++) bus_out(16'h003F, exp4[k]);
      for (int k = 0; k < 4; k++) begin
         wait_got(k + 1, "four");
         repeat (128) @(negedge clk);
         psg_ready = 1'b1;
         for (int i = 0; i < 20 && psg_wr_n !== 1'b1; i++) @(negedge clk);
         psg_ready = 1'b0;
      end
      repeat (20) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         checks++; if (got.size() <= k || got[k] !== exp4[k]) begin errors++; $display("FAIL four_byte%0d: got %h want %h", k, got.size() > k ? got[k] : 8'h00, exp4[k]); end
      end
      checks++; if (lvl_max != 3 && lvl_max != 4) begin errors++; $display("FAIL four_level_peak: got %0d want 3 or 4", lvl_max); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL four_overflow: got %b want 0", overflow); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL four_wdata_stable: got %0d changes want 0", unstable); end
   endtask

   task automatic test_overflow;
      psg_ready = 1'b0;
      got.delete();
      // one byte parks in WAIT, eight fill the FIFO, the tenth is dropped
      for (int i = 1; i <= 10; i++) bus_out(16'hAB3F, 8'(i));
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d want 8", level); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
      @(negedge clk); clear_overflow = 1'b1;
      @(negedge clk); clear_overflow = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
      @(negedge clk);
      address = 16'h003F; wdata = 8'h0B; n_ioreq = 1'b0; n_wr = 1'b0; clear_overflow = 1'b1;
      @(negedge clk);
      n_ioreq = 1'b1; n_wr = 1'b1; clear_overflow = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level_hold: got %0d want 8", level); end
      @(negedge clk); clear_overflow = 1'b1;
      @(negedge clk); clear_overflow = 1'b0;
      psg_ready = 1'b1;
      wait_got(9, "ovf");
      repeat (60) @(negedge clk);
      checks++; if (got.size() != 9) begin errors++; $display("FAIL ovf_count: got %0d want 9", got.size()); end
      for (int i = 0; i < 9; i++) begin
         checks++; if (got.size() <= i || got[i] !== 8'(i + 1)) begin errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, got.size() > i ? got[i] : 8'h00, 8'(i + 1)); end
      end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b want 0", overflow); end
   endtask

   task automatic test_hold_port;
      en_run = 1'b0;
      psg_ready = 1'b0;
      got.delete();
      @(negedge clk);
      address = 16'h003F; wdata = 8'h55; n_ioreq = 1'b0; n_wr = 1'b0;
      @(negedge clk);
      wdata = 8'h77;
      repeat (9) @(negedge clk);
      n_ioreq = 1'b1; n_wr = 1'b1;
      bus_out(16'h127F, 8'h66);
      @(negedge clk);
      checks++; if (level !== 4'd1) begin errors++; $display("FAIL hold_level: got %0d want 1", level); end
      psg_ready = 1'b1;
      en_run = 1'b1;
      wait_got(1, "hold");
      repeat (30) @(negedge clk);
      checks++; if (got.size() != 1 || got[0] !== 8'h55) begin errors++; $display("FAIL hold_data: got %0d bytes first %h want 1 byte 55", got.size(), got.size() ? got[0] : 8'h00); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL hold_level0: got %0d want 0", level); end
   endtask

   task automatic test_back_to_back;
      en_run = 1'b0;
      psg_ready = 1'b0;
      got.delete();
      for (int i = 0; i < 8; i++) bus_out(16'h003F, 8'(8'h10 + i));
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL b2b_full: got %0d want 8", level); end
      @(negedge clk);
      en_man = 1'b1; address = 16'h003F; wdata = 8'h18; n_ioreq = 1'b0; n_wr = 1'b0;
      @(negedge clk);
      en_man = 1'b0; n_ioreq = 1'b1; n_wr = 1'b1;
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL b2b_level: got %0d want 8", level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
      checks++; if (psg_wr_n !== 1'b0 || psg_wdata !== 8'h10) begin errors++; $display("FAIL b2b_head: got wr=%b data=%h want 0 10", psg_wr_n, psg_wdata); end
      psg_ready = 1'b1;
      en_run = 1'b1;
      wait_got(9, "b2b");
      repeat (40) @(negedge clk);
      checks++; if (got.size() != 9) begin errors++; $display("FAIL b2b_count: got %0d want 9", got.size()); end
      for (int i = 0; i < 9; i++) begin
         checks++; if (got.size() <= i || got[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, got.size() > i ? got[i] : 8'h00, 8'(8'h10 + i)); end
      end
   endtask

   task automatic test_reset_mid;
      en_run = 1'b0;
      psg_ready = 1'b0;
      got.delete();
      for (int i = 0; i < 6; i++) bus_out(16'h003F, 8'(8'h20 + i));
      @(negedge clk); en_man = 1'b1;
      @(negedge clk); en_man = 1'b0;
      checks++; if (level !== 4'd5) begin errors++; $display("FAIL rmid_level5: got %0d want 5", level); end
      checks++; if (psg_ce_n !== 1'b0 || psg_wr_n !== 1'b0) begin errors++; $display("FAIL rmid_wait: got ce=%b wr=%b want 0 0", psg_ce_n, psg_wr_n); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (psg_ce_n !== 1'b1 || psg_wr_n !== 1'b1) begin errors++; $display("FAIL rmid_strobes: got ce=%b wr=%b want 1 1", psg_ce_n, psg_wr_n); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL rmid_level0: got %0d want 0", level); end
      checks++; if (psg_wdata !== 8'h00) begin errors++; $display("FAIL rmid_wdata: got %h want 00", psg_wdata); end
      reset = 1'b0;
      psg_ready = 1'b1;
      en_run = 1'b1;
      repeat (60) @(negedge clk);
      checks++; if (got.size() != 1) begin errors++; $display("FAIL rmid_no_writes: got %0d bytes want 1", got.size()); end
      checks++; if (psg_ce_n !== 1'b1 || level !== 4'd0) begin errors++; $display("FAIL rmid_idle: got ce=%b level=%0d want 1 0", psg_ce_n, level); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_four();
      test_overflow();
      test_hold_port();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
